// File: rtl/eq_diff_checker.sv
// eq_diff_checker: lock-step comparator of golden vs netlist output streams (optional EQ_CHK_STOP_ON_MISMATCH_EN ends a run at the first mismatch)
module eq_diff_checker #(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 4,
    parameter int NUM_VEC = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ref_valid,
    input  logic [WIDTH-1:0] ref_data,
    output logic             ref_ready,
    input  logic             dut_valid,
    input  logic [WIDTH-1:0] dut_data,
    output logic             dut_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             overflow,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_ref,
    output logic [WIDTH-1:0] first_dut
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] dut_mem [DEPTH];
    logic [AW:0] ref_wp, ref_rp, dut_wp, dut_rp;
    logic [CNT_W-1:0] vec_idx, cnt_nxt;
    logic [WIDTH-1:0] ref_head, dut_head;
    logic ref_full, dut_full, ref_empty, dut_empty, ref_push, dut_push;
    logic pop, neq, last, stop, ovf_evt, clear;

    assign busy      = state == RUN;
    assign done      = state == DONE;
    assign ref_full  = (ref_wp[AW-1:0] == ref_rp[AW-1:0]) && (ref_wp[AW] != ref_rp[AW]);
    assign dut_full  = (dut_wp[AW-1:0] == dut_rp[AW-1:0]) && (dut_wp[AW] != dut_rp[AW]);
    assign ref_empty = ref_wp == ref_rp;
    assign dut_empty = dut_wp == dut_rp;
    assign ref_ready = busy && !ref_full;
    assign dut_ready = busy && !dut_full;
    assign ref_push  = ref_valid && ref_ready;
    assign dut_push  = dut_valid && dut_ready;
    assign ovf_evt   = busy && ((ref_valid && ref_full) || (dut_valid && dut_full));
    assign pop       = busy && !ref_empty && !dut_empty;
    assign ref_head  = ref_mem[ref_rp[AW-1:0]];
    assign dut_head  = dut_mem[dut_rp[AW-1:0]];
    assign neq       = ref_head != dut_head;
    assign last      = pop && (vec_idx == CNT_W'(NUM_VEC - 1));
    assign clear     = start && !busy;
    assign cnt_nxt   = (pop && neq && mismatch_cnt != '1) ? mismatch_cnt + 1'b1 : mismatch_cnt;
`ifdef EQ_CHK_STOP_ON_MISMATCH_EN
    assign stop      = pop && neq;
`else
    assign stop      = 1'b0;
`endif

    // next state: start launches a run from IDLE/DONE, run ends on last compare, overflow or stop
    always_comb begin
        state_nxt = state;
        if (busy)
            state_nxt = (last || ovf_evt || stop) ? DONE : RUN;
        else if (start)
            state_nxt = RUN;
    end

    // sample storage; contents are don't-care until pointers cover them
    always_ff @(posedge clk) begin
        if (ref_push) ref_mem[ref_wp[AW-1:0]] <= ref_data;
        if (dut_push) dut_mem[dut_wp[AW-1:0]] <= dut_data;
    end

    // state, FIFO pointers, compare bookkeeping and run result
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ref_wp       <= '0;
            ref_rp       <= '0;
            dut_wp       <= '0;
            dut_rp       <= '0;
            vec_idx      <= '0;
            mismatch_cnt <= '0;
            first_idx    <= '0;
            first_ref    <= '0;
            first_dut    <= '0;
            overflow     <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                ref_wp       <= '0;
                ref_rp       <= '0;
                dut_wp       <= '0;
                dut_rp       <= '0;
                vec_idx      <= '0;
                mismatch_cnt <= '0;
                first_idx    <= '0;
                first_ref    <= '0;
                first_dut    <= '0;
                overflow     <= 1'b0;
                pass         <= 1'b0;
            end else if (busy) begin
                if (state_nxt == DONE) begin
                    ref_wp <= '0;
                    ref_rp <= '0;
                    dut_wp <= '0;
                    dut_rp <= '0;
                    pass   <= (cnt_nxt == '0) && !ovf_evt;
                end else begin
                    if (ref_push) ref_wp <= ref_wp + 1'b1;
                    if (dut_push) dut_wp <= dut_wp + 1'b1;
                    if (pop) ref_rp <= ref_rp + 1'b1;
                    if (pop) dut_rp <= dut_rp + 1'b1;
                end
                if (pop) begin
                    vec_idx      <= vec_idx + 1'b1;
                    mismatch_cnt <= cnt_nxt;
                    if (neq && mismatch_cnt == '0) begin
                        first_idx <= vec_idx;
                        first_ref <= ref_head;
                        first_dut <= dut_head;
                    end
                end
                if (ovf_evt) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_eq_diff_checker.sv
// tb_eq_diff_checker: scoreboard bench for eq_diff_checker (main instance NUM_VEC=8, second instance CNT_W=2/NUM_VEC=4)
module tb_eq_diff_checker;
`ifdef EQ_CHK_STOP_ON_MISMATCH_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    typedef struct {
        logic [15:0] cnt;
        logic [15:0] fidx;
        logic        fr;
        logic        fd;
        logic        pass;
        logic        ovf;
    } exp_t;

    logic clk = 0, rst = 0, start = 0, rv = 0, rd = 0, dv = 0, dd = 0;
    logic ref_ready, dut_ready, busy, done, pass, overflow, first_ref, first_dut;
    logic [15:0] mismatch_cnt, first_idx;
    logic s_ref_ready, s_dut_ready, s_busy, s_done, s_pass, s_overflow, s_first_ref, s_first_dut;
    logic [1:0] s_mismatch_cnt, s_first_idx;
    int tests = 0, fails = 0;
    bit ready_drop;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    eq_diff_checker #(.WIDTH(1), .DEPTH(4), .NUM_VEC(8), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .ref_valid(rv), .ref_data(rd), .ref_ready(ref_ready),
        .dut_valid(dv), .dut_data(dd), .dut_ready(dut_ready),
        .busy(busy), .done(done), .pass(pass), .overflow(overflow),
        .mismatch_cnt(mismatch_cnt), .first_idx(first_idx),
        .first_ref(first_ref), .first_dut(first_dut)
    );

    eq_diff_checker #(.WIDTH(1), .DEPTH(4), .NUM_VEC(4), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .ref_valid(rv), .ref_data(rd), .ref_ready(s_ref_ready),
        .dut_valid(dv), .dut_data(dd), .dut_ready(s_dut_ready),
        .busy(s_busy), .done(s_done), .pass(s_pass), .overflow(s_overflow),
        .mismatch_cnt(s_mismatch_cnt), .first_idx(s_first_idx),
        .first_ref(s_first_ref), .first_dut(s_first_dut)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // independent reference model of one full run of n pairs
    function automatic exp_t model(input logic [7:0] r, input logic [7:0] d, input int n, input logic [15:0] cmax);
        exp_t m = '{default: '0};
        bit stopped = 0;
        for (int i = 0; i < n; i++) begin
            if (!stopped && r[i] != d[i]) begin
                if (m.cnt == 0) begin
                    m.fidx = 16'(i);
                    m.fr = r[i];
                    m.fd = d[i];
                end
                if (m.cnt < cmax) m.cnt = m.cnt + 1;
                if (STOP) stopped = 1;
            end
        end
        m.pass = m.cnt == 0;
        return m;
    endfunction

    task automatic do_reset();
        rst = 1; start = 0; rv = 0; dv = 0; rd = 0; dd = 0;
        tick();
        rst = 0;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    // drive n pairs with the dut stream delayed by lag cycles; expected result queued up front
    task automatic drive(input logic [7:0] r, input logic [7:0] d, input int n, input int lag, input logic [15:0] cmax);
        q.push_back(model(r, d, n, cmax));
        ready_drop = 0;
        for (int t = 0; t < n + lag; t++) begin
            rv = t < n;
            rd = (t < n) ? r[t] : 1'b0;
            dv = (t >= lag) && (t - lag < n);
            dd = dv ? d[t - lag] : 1'b0;
            if (rv && !ref_ready) ready_drop = 1;
            tick();
        end
        rv = 0; dv = 0; rd = 0; dd = 0;
    endtask

    task automatic wait_done(input bit sel);
        for (int i = 0; i < 20 && !(sel ? s_done : done); i++) tick();
        tests++;
        if (!(sel ? s_done : done)) begin
            fails++;
            $display("FAIL done_timeout: done=0 required 1 after 20 cycles");
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({busy, done, pass, overflow, ref_ready, dut_ready} !== 6'b0) begin
            fails++;
            $display("FAIL reset_status: got %b required 000000", {busy, done, pass, overflow, ref_ready, dut_ready});
        end
        tests++;
        if ({mismatch_cnt, first_idx, first_ref, first_dut} !== 34'b0) begin
            fails++;
            $display("FAIL reset_counters: cnt=%0d idx=%0d ref=%b dut=%b required all 0", mismatch_cnt, first_idx, first_ref, first_dut);
        end
    endtask

    task automatic check_main(input string name);
        e = q.pop_front();
        tests++;
        if (mismatch_cnt !== e.cnt) begin
            fails++;
            $display("FAIL %s_cnt: got %0d required %0d", name, mismatch_cnt, e.cnt);
        end
        tests++;
        if ({first_idx, first_ref, first_dut} !== {e.fidx, e.fr, e.fd}) begin
            fails++;
            $display("FAIL %s_first: got idx=%0d ref=%b dut=%b required idx=%0d ref=%b dut=%b", name, first_idx, first_ref, first_dut, e.fidx, e.fr, e.fd);
        end
        tests++;
        if ({busy, done, pass, overflow, ref_ready, dut_ready} !== {2'b01, e.pass, e.ovf, 2'b00}) begin
            fails++;
            $display("FAIL %s_status: got %b required %b", name, {busy, done, pass, overflow, ref_ready, dut_ready}, {2'b01, e.pass, e.ovf, 2'b00});
        end
    endtask

    task automatic test_lockstep();
        do_start();
        drive(8'h5A, 8'h5A, 8, 0, 16'hFFFF);
        wait_done(0);
        check_main("lockstep");
    endtask

    task automatic test_mismatch();
        do_start();
        drive(8'b0100_0101, 8'b0110_0001, 8, 0, 16'hFFFF);
        wait_done(0);
        check_main("mismatch");
    endtask

    task automatic test_skew();
        do_reset();
        do_start();
        drive(8'hC3, 8'hC3, 8, 2, 16'hFFFF);
        tests++;
        if (ready_drop !== 1'b0) begin
            fails++;
            $display("FAIL skew_ready: ref_ready dropped=%b required 0", ready_drop);
        end
        wait_done(0);
        check_main("skew");
    endtask

    task automatic test_overflow();
        do_reset();
        do_start();
        q.push_back('{cnt: 16'd0, fidx: 16'd0, fr: 1'b0, fd: 1'b0, pass: 1'b0, ovf: 1'b1});
        rv = 1; rd = 1;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (ref_ready !== 1'b0) begin
            fails++;
            $display("FAIL overflow_ready: ref_ready=%b required 0 with 4 queued", ref_ready);
        end
        tick();
        rv = 0; rd = 0;
        wait_done(0);
        check_main("overflow");
    endtask

    task automatic test_back_to_back();
        do_start();
        drive(8'h96, 8'h96, 8, 0, 16'hFFFF);
        wait_done(0);
        check_main("back_to_back");
    endtask

    task automatic test_reset_midrun();
        do_reset();
        do_start();
        for (int t = 0; t < 3; t++) begin
            rv = 1; dv = 1; rd = (t == 1); dd = 0;
            tick();
        end
        rv = 0; dv = 0; rd = 0;
        tick();
        tests++;
        if ({mismatch_cnt, first_idx, first_ref, first_dut} !== {16'd1, 16'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL midrun_pre: cnt=%0d idx=%0d ref=%b dut=%b required 1 1 1 0", mismatch_cnt, first_idx, first_ref, first_dut);
        end
        rst = 1;
        tick();
        rst = 0;
        tests++;
        if ({busy, done, pass, overflow, ref_ready, dut_ready, mismatch_cnt, first_idx, first_ref, first_dut} !== 40'b0) begin
            fails++;
            $display("FAIL midrun_post: busy=%b done=%b cnt=%0d idx=%0d ref=%b dut=%b ready=%b%b required all 0", busy, done, mismatch_cnt, first_idx, first_ref, first_dut, ref_ready, dut_ready);
        end
        do_start();
        drive(8'h3C, 8'h3C, 8, 0, 16'hFFFF);
        wait_done(0);
        check_main("midrun_restart");
    endtask

    task automatic test_saturation();
        do_reset();
        do_start();
        drive(8'h0F, 8'h00, 4, 0, 16'd3);
        wait_done(1);
        e = q.pop_front();
        tests++;
        if (s_mismatch_cnt !== e.cnt[1:0]) begin
            fails++;
            $display("FAIL sat_cnt: got %0d required %0d", s_mismatch_cnt, e.cnt[1:0]);
        end
        tests++;
        if ({s_first_idx, s_first_ref, s_first_dut} !== {e.fidx[1:0], e.fr, e.fd}) begin
            fails++;
            $display("FAIL sat_first: got idx=%0d ref=%b dut=%b required idx=%0d ref=%b dut=%b", s_first_idx, s_first_ref, s_first_dut, e.fidx[1:0], e.fr, e.fd);
        end
        tests++;
        if ({s_busy, s_done, s_pass, s_overflow} !== {2'b01, e.pass, e.ovf}) begin
            fails++;
            $display("FAIL sat_status: got %b required %b", {s_busy, s_done, s_pass, s_overflow}, {2'b01, e.pass, e.ovf});
        end
    endtask

    initial begin
        test_reset();
        test_lockstep();
        test_mismatch();
        test_skew();
        test_overflow();
        test_back_to_back();
        test_reset_midrun();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
